// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - RV32M multi-cycle multiply/divide sequencer
// Define MDU_EARLY_OUT_EN to let divide-by-zero, divide overflow and zero-operand multiplies skip CALC.
module mdu_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] ReadData1,
   input  logic [XLEN-1:0] ReadData2,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] MDUResult
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [2:0]      f3;
   logic            sign_a, sign_b, a_zero, b_zero, ovf;
   logic [XLEN-1:0] a_abs, b_abs;
   logic [XLEN-1:0] hi, lo;

   logic            accept, early, is_div_in, signed_a_in, signed_b_in;
   logic            neg_a_in, neg_b_in, az_in, bz_in, ovf_in;
   logic [XLEN-1:0] a_abs_in, b_abs_in;
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic [XLEN-1:0] hi_nx, lo_nx, fix_result, quot_s, rem_s, a_orig;
   logic [2*XLEN-1:0] prod, prod_s;

   // Operand decode: A is signed for mul/mulh/mulhsu/div/rem, B for mul/mulh/div/rem
   always_comb begin
      is_div_in   = funct3[2];
      signed_a_in = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2) ||
                    (funct3 == 3'd4) || (funct3 == 3'd6);
      signed_b_in = (funct3 == 3'd0) || (funct3 == 3'd1) ||
                    (funct3 == 3'd4) || (funct3 == 3'd6);
      neg_a_in    = signed_a_in & ReadData1[XLEN-1];
      neg_b_in    = signed_b_in & ReadData2[XLEN-1];
      a_abs_in    = neg_a_in ? -ReadData1 : ReadData1;
      b_abs_in    = neg_b_in ? -ReadData2 : ReadData2;
      az_in       = (ReadData1 == '0);
      bz_in       = (ReadData2 == '0);
      ovf_in      = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                    (ReadData1 == MIN_NEG) && (ReadData2 == '1);
      accept      = start & ~kill & ((state == IDLE) || (state == DONE));
   end

`ifdef MDU_EARLY_OUT_EN
   assign early = is_div_in ? (bz_in | ovf_in) : (az_in | bz_in);
`else
   assign early = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      busy     = (state == CALC) || (state == FIX);
      done     = (state == DONE);
      if (accept) begin
         state_nx = early ? FIX : CALC;
      end else begin
         case (state)
            CALC:    if (kill) state_nx = IDLE;
                     else if (cnt == CW'(XLEN-1)) state_nx = FIX;
            FIX:     state_nx = kill ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_abs} : {(XLEN+1){1'b0}});
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_abs};
      if (f3[2]) begin
         hi_nx = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
         lo_nx = {lo[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
         hi_nx = mul_sum[XLEN:1];
         lo_nx = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   always_comb begin
      prod       = {hi, lo};
      prod_s     = (sign_a ^ sign_b) ? -prod : prod;
      quot_s     = (sign_a ^ sign_b) ? -lo : lo;
      rem_s      = sign_a ? -hi : hi;
      a_orig     = sign_a ? -a_abs : a_abs;
      fix_result = '0;
      case (f3)
         3'd0:             fix_result = (a_zero | b_zero) ? '0 : prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fix_result = (a_zero | b_zero) ? '0 : prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fix_result = b_zero ? '1 : (ovf ? MIN_NEG : quot_s);
         default:          fix_result = b_zero ? a_orig : (ovf ? '0 : rem_s);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         f3        <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         a_zero    <= 1'b0;
         b_zero    <= 1'b0;
         ovf       <= 1'b0;
         a_abs     <= '0;
         b_abs     <= '0;
         hi        <= '0;
         lo        <= '0;
         MDUResult <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt    <= '0;
            f3     <= funct3;
            sign_a <= neg_a_in;
            sign_b <= neg_b_in;
            a_zero <= az_in;
            b_zero <= bz_in;
            ovf    <= ovf_in;
            a_abs  <= a_abs_in;
            b_abs  <= b_abs_in;
            hi     <= '0;
            lo     <= is_div_in ? a_abs_in : b_abs_in;
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nx;
            lo  <= lo_nx;
         end
         if ((state == FIX) && !kill)
            MDUResult <= fix_result;
      end
   end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed vector bench for mdu_sequencer
module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, kill;
   logic [2:0]  funct3;
   logic [31:0] ReadData1, ReadData2;
   logic        busy, done;
   logic [31:0] MDUResult;

   int total = 0;
   int bad   = 0;

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   mdu_sequencer #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .kill(kill),
      .busy(busy), .done(done), .MDUResult(MDUResult)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          sp;
   } vec_t;

   vec_t vecs [22];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one op in the current cycle (N); returns in its DONE cycle, or after 40 cycles
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit busy_ok);
      funct3 = f; ReadData1 = a; ReadData2 = b; start = 1'b1;
      tick();
      start   = 1'b0;
      lat     = 0;
      res     = 'x;
      busy_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            lat = k;
            res = MDUResult;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         tick();
      end
   endtask

   initial begin
      int          lat, exp_lat, dones;
      logic [31:0] res;
      bit          bok;

      vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
      vecs[4]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
      vecs[5]  = '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0};
      vecs[6]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
      vecs[7]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1};
      vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0};
      vecs[11] = '{3'd2, 32'd2,         32'hFFFF_FFFF, 32'd1,         1'b0};
      vecs[12] = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0};
      vecs[13] = '{3'd0, 32'd0,         32'd12345,     32'd0,         1'b1};
      vecs[14] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
      vecs[15] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
      vecs[16] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
      vecs[17] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};
      vecs[18] = '{3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1,         1'b0};
      vecs[19] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0};
      vecs[20] = '{3'd7, 32'd9,         32'd0,         32'd9,         1'b1};
      vecs[21] = '{3'd1, 32'd5,         32'd0,         32'd0,         1'b1};

      rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = '0; ReadData1 = '0; ReadData2 = '0;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_outputs", {30'd0, busy, done}, 32'd0);
      check("reset_result", MDUResult, 32'd0);

      // Table vectors; each op after the first starts in the previous op's DONE cycle
      for (int i = 0; i < 22; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, lat, res, bok);
         exp_lat = (vecs[i].sp && EARLY) ? 2 : 34;
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), lat, exp_lat);
         check($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
      end
      tick();
      check("done_one_pulse", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);

      // start held high through busy with operands changing mid-flight
      funct3 = 3'd0; ReadData1 = 32'd3; ReadData2 = 32'd5; start = 1'b1;
      tick();
      ReadData1 = 32'd100;
      dones = 0;
      res = '0;
      for (int k = 1; k <= 70; k++) begin
         if (done) begin
            dones++;
            res = MDUResult;
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      check("held_start_done_count", dones, 32'd1);
      check("held_start_result", res, 32'd15);

      // Back-to-back: second start issued in the DONE cycle of the first
      run_op(3'd0, 32'd3, 32'd5, lat, res, bok);
      check("b2b_first_result", res, 32'd15);
      run_op(3'd5, 32'd100, 32'd7, lat, res, bok);
      check("b2b_second_latency", lat, 32'd34);
      check("b2b_second_result", res, 32'd14);
      tick();

      // kill at N+10
      funct3 = 3'd5; ReadData1 = 32'd100; ReadData2 = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill_busy_low", {30'd0, busy, done}, 32'd0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) dones++;
         tick();
      end
      check("kill_no_done", dones, 32'd0);
      check("kill_result_held", MDUResult, 32'd14);

      // rst at N+5
      funct3 = 3'd3; ReadData1 = 32'd9; ReadData2 = 32'd9; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midop_reset_flags", {30'd0, busy, done}, 32'd0);
      check("midop_reset_result", MDUResult, 32'd0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) dones++;
         tick();
      end
      check("midop_reset_no_done", dones, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
